// File: rtl/uart_test_if.sv
// uart_test_if: serial pins and transmit handshake of the uart_test loopback block.
// The slave modport is the DUT side and the master modport is the board/bench side.
interface uart_test_if;
    logic RxD;
    logic TxD_start;
    logic RxD_data_ready;
    logic TxD;
    logic TxD_busy;

    modport slave (
        input  RxD,
        input  TxD_start,
        output RxD_data_ready,
        output TxD,
        output TxD_busy
    );

    modport master (
        output RxD,
        output TxD_start,
        input  RxD_data_ready,
        input  TxD,
        input  TxD_busy
    );
endinterface

// File: rtl/uart_test.sv
// uart_test: UART 8N1 loopback test block. Bytes received on RxD go into a
// holding register, and the held byte is retransmitted on TxD on request.
// Optional feature macro: UART_TEST_AUTO_ECHO_EN. When it is defined, every
// good received byte is echoed automatically.

// async_transmitter: 8N1 serial transmitter with one down-counter per bit.
module async_transmitter #(
    parameter int BIT_CYCLES = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TxD,
    output logic       busy
);
    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;

    // Frame sequencer; TxD and busy are registered so they switch exactly on bit edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            TxD   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        shreg <= data;
                        cnt   <= BIT_RELOAD;
                        TxD   <= 1'b0;
                        busy  <= 1'b1;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        cnt   <= BIT_RELOAD;
                        TxD   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        idx   <= '0;
                        state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        cnt <= BIT_RELOAD;
                        if (idx == 3'd7) begin
                            TxD   <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            TxD   <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                            idx   <= idx + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (start) begin
                        // The end of the stop bit also accepts a new request, so busy never drops
                        shreg <= data;
                        cnt   <= BIT_RELOAD;
                        TxD   <= 1'b0;
                        state <= TX_START;
                    end else begin
                        busy  <= 1'b0;
                        state <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end
endmodule

module uart_test #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_test_if.slave  bus
);
    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BIT_CYCLES / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic             rx_s1, rx_s2, rx_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shreg;
    logic [7:0]       hold_reg;
    logic             rx_ready;
    logic             start_q;
    logic [7:0]       data_q;

    assign bus.RxD_data_ready = rx_ready;

    // Two-flop synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.RxD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver: mid-bit sampling, holding-register update and ready pulse on a good stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shreg <= '0;
            hold_reg <= '0;
            rx_ready <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt   <= HALF_RELOAD;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end else if (rx_s2) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt   <= BIT_RELOAD;
                        rx_idx   <= '0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end else begin
                        rx_cnt   <= BIT_RELOAD;
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end else begin
                        if (rx_s2) begin
                            hold_reg <= rx_shreg;
                            rx_ready <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Start request and the held byte are registered on the same edge. If a good-frame
    // write lands on that edge, the transmitter still gets the pre-write holding value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            data_q  <= '0;
        end else begin
`ifdef UART_TEST_AUTO_ECHO_EN
            start_q <= bus.TxD_start | rx_ready;
`else
            start_q <= bus.TxD_start;
`endif
            data_q  <= hold_reg;
        end
    end

    async_transmitter #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_q),
        .data  (data_q),
        .TxD   (bus.TxD),
        .busy  (bus.TxD_busy)
    );
endmodule

// File: tb/tb_uart_test.sv
// tb_uart_test: directed, table-driven bench for the uart_test loopback block at 50 MHz / 115200.
module tb_uart_test;
    localparam int BIT   = 434;
    localparam int FRAME = 10 * BIT;

    typedef struct {
        logic [7:0] rx_byte;
        logic       stop_bit;
        int         exp_ready;
        logic [7:0] exp_tx;
        int         hold;
        bit         mid_pulse;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ready_cnt = 0;

    uart_test_if u_if();

    uart_test #(
        .CLK_FREQ(50_000_000),
        .BAUD(115200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.RxD_data_ready === 1'b1) ready_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [7:0] d;
        d = b;
        u_if.RxD = 1'b0;
        cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            u_if.RxD = d[i];
            cycles(BIT);
        end
        u_if.RxD = stop_bit;
        cycles(BIT);
        u_if.RxD = 1'b1;
        cycles(BIT);
    endtask

    task automatic tx_frame(input int hold, input bit mid_pulse, input logic [7:0] exp_b, input string tag);
        logic [9:0] bits;
        logic [9:0] exp_bits;
        int cyc;
        bits = '1;
        exp_bits = {1'b1, exp_b, 1'b0};
        u_if.TxD_start = 1'b1;
        cycles(1);
        if (hold < 2) u_if.TxD_start = 1'b0;
        cycles(1);
        check({tag, "_lat_txd"}, 32'(u_if.TxD), 32'd0);
        check({tag, "_lat_busy"}, 32'(u_if.TxD_busy), 32'd1);
        cyc = 0;
        while (u_if.TxD_busy === 1'b1 && cyc < FRAME + 50) begin
            if (cyc == 0) u_if.TxD_start = 1'b0;
            if (mid_pulse && cyc == 2000) u_if.TxD_start = 1'b1;
            if (mid_pulse && cyc == 2001) u_if.TxD_start = 1'b0;
            if ((cyc % BIT) == BIT / 2 && (cyc / BIT) < 10) bits[cyc / BIT] = u_if.TxD;
            cycles(1);
            cyc++;
        end
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_busy_len"}, 32'(cyc), 32'(FRAME));
        check({tag, "_idle_txd"}, 32'(u_if.TxD), 32'd1);
    endtask

`ifdef UART_TEST_AUTO_ECHO_EN
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (u_if.TxD_busy === 1'b1 && n < 2 * FRAME) begin
            cycles(1);
            n++;
        end
        check({tag, "_echo_done"}, 32'(u_if.TxD_busy), 32'd0);
    endtask
`endif

    vec_t vecs[4];

    initial begin
        vecs[0] = '{rx_byte: 8'h97, stop_bit: 1'b1, exp_ready: 1, exp_tx: 8'h97, hold: 2, mid_pulse: 1'b0};
        vecs[1] = '{rx_byte: 8'h81, stop_bit: 1'b1, exp_ready: 1, exp_tx: 8'h81, hold: 1, mid_pulse: 1'b1};
        vecs[2] = '{rx_byte: 8'h3C, stop_bit: 1'b0, exp_ready: 0, exp_tx: 8'h81, hold: 1, mid_pulse: 1'b0};
        vecs[3] = '{rx_byte: 8'hA5, stop_bit: 1'b1, exp_ready: 1, exp_tx: 8'hA5, hold: 1, mid_pulse: 1'b1};

        u_if.RxD = 1'b1;
        u_if.TxD_start = 1'b0;
        cycles(3);
        check("rst_txd", 32'(u_if.TxD), 32'd1);
        check("rst_busy", 32'(u_if.TxD_busy), 32'd0);
        check("rst_ready", 32'(u_if.RxD_data_ready), 32'd0);
        rst_n = 1'b1;
        cycles(2);
        tx_frame(1, 1'b0, 8'h00, "rst_frame");

        for (int v = 0; v < 4; v++) begin
            ready_cnt = 0;
            send_byte(vecs[v].rx_byte, vecs[v].stop_bit);
            check($sformatf("v%0d_ready_cnt", v), 32'(ready_cnt), 32'(vecs[v].exp_ready));
`ifdef UART_TEST_AUTO_ECHO_EN
            wait_idle($sformatf("v%0d", v));
`endif
            tx_frame(vecs[v].hold, vecs[v].mid_pulse, vecs[v].exp_tx, $sformatf("v%0d", v));
        end

        // One-cycle glitch must not produce a byte, and the receiver must still take the next frame
        ready_cnt = 0;
        u_if.RxD = 1'b0;
        cycles(1);
        u_if.RxD = 1'b1;
        cycles(2 * BIT);
        check("glitch_ready", 32'(ready_cnt), 32'd0);
        check("glitch_busy", 32'(u_if.TxD_busy), 32'd0);
        send_byte(8'h97, 1'b1);
        check("post_glitch_ready", 32'(ready_cnt), 32'd1);
`ifdef UART_TEST_AUTO_ECHO_EN
        check("echo_started", 32'(u_if.TxD_busy), 32'd1);
        wait_idle("post_glitch");
`else
        check("no_echo", 32'(u_if.TxD_busy), 32'd0);
`endif
        tx_frame(1, 1'b0, 8'h97, "post_glitch");

        // Reset in the middle of a frame aborts it at once and clears the holding register
        u_if.TxD_start = 1'b1;
        cycles(1000);
        rst_n = 1'b0;
        #1;
        check("midrst_txd", 32'(u_if.TxD), 32'd1);
        check("midrst_busy", 32'(u_if.TxD_busy), 32'd0);
        check("midrst_ready", 32'(u_if.RxD_data_ready), 32'd0);
        u_if.TxD_start = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        tx_frame(1, 1'b0, 8'h00, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
